// File: rtl/ps2_kbd_port.sv
// ps2_kbd_port: PS/2 keyboard receiver with a scancode FIFO, exposed as a 16-bit I/O port.
// Frames are synchronised, checked for odd parity and stop bit, then queued for the CPU.
module ps2_kbd_port #(
    parameter int clk_freq       = 50000000,
    parameter int fifo_depth     = 8,
    parameter int timeout_cycles = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        data_m_access,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    input  logic [15:0] data_m_data_in,
    output logic [15:0] data_m_data_out,
    output logic        data_m_ack,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic        intr
);
    localparam int aw = $clog2(fifo_depth);
    localparam int cw = aw + 1;
    // Timer is sized to cover the frame timeout or one slowest (10 kHz) PS/2 bit, whichever is longer.
    localparam int bit_max = clk_freq / 10000;
    localparam int tmo_max = (timeout_cycles > bit_max) ? timeout_cycles : bit_max;
    localparam int tw = $clog2(tmo_max + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_PAR  = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          clk_prev_q, fall_q, bit_q;
    logic [1:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [tw-1:0] tmo_q, tmo_d;
    logic          push, bad;

    logic [7:0]    mem_q [fifo_depth];
    logic [aw-1:0] wp_q, rp_q;
    logic [cw-1:0] count_q;
    logic          ovf_q, ferr_q, irq_en_q, ack_q, intr_q;
    logic [15:0]   rdata_q, word;
    logic          acc, wr_acc, pop, full, push_ok, not_empty;
    logic          unused_bits;

    assign unused_bits = &{1'b0, data_m_bytesel[0], data_m_data_in[13:12], data_m_data_in[10:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_dat};
            clk_prev_q <= clk_sync_q[1];
            fall_q     <= clk_prev_q & ~clk_sync_q[1];
            bit_q      <= dat_sync_q[1];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        push    = 1'b0;
        bad     = 1'b0;
        tmo_d   = (fall_q || state_q == S_IDLE) ? '0 : tmo_q + 1'b1;
        if (fall_q) begin
            case (state_q)
                S_IDLE: if (!bit_q) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
                S_DATA: begin
                    shift_d = {bit_q, shift_q[7:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == 3'd7) state_d = S_PAR;
                end
                S_PAR: begin
                    par_d   = bit_q;
                    state_d = S_STOP;
                end
                default: begin
                    push    = bit_q & (^shift_q ^ par_q);
                    bad     = ~push;
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q != S_IDLE && tmo_q == tw'(timeout_cycles - 1)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tmo_q   <= tmo_d;
        end
    end

    assign acc       = cs & data_m_access & ~ack_q;
    assign wr_acc    = acc & data_m_wr_en & data_m_bytesel[1];
    assign not_empty = count_q != '0;
    assign pop       = wr_acc & data_m_data_in[15] & not_empty;
    assign full      = count_q == cw'(fifo_depth);
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign push_ok   = push & (~full | pop);
    assign word      = {4'h0, irq_en_q, ferr_q, ovf_q, not_empty, not_empty ? mem_q[rp_q] : 8'h00};

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q] <= shift_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp_q     <= '0;
            rp_q     <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            irq_en_q <= 1'b0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            intr_q   <= 1'b0;
        end else begin
            wp_q    <= wp_q + aw'(push_ok);
            rp_q    <= rp_q + aw'(pop);
            count_q <= count_q + cw'(push_ok) - cw'(pop);
            if (wr_acc && data_m_data_in[14]) begin
                ovf_q  <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (push && !push_ok) ovf_q <= 1'b1;
            if (bad) ferr_q <= 1'b1;
            if (wr_acc) irq_en_q <= data_m_data_in[11];
            ack_q   <= acc;
            rdata_q <= acc ? word : 16'h0000;
            intr_q  <= irq_en_q & not_empty;
        end
    end

    assign data_m_ack      = ack_q;
    assign data_m_data_out = rdata_q;
    assign intr            = intr_q;
endmodule

// File: doc/ps2_kbd_port.md
# ps2_kbd_port

PS/2 keyboard receiver exposed as a 16-bit I/O port on the CPU data bus, selected by a `cs` from the top-level I/O address decode alongside the UART, SPI and timer ports. It deserialises PS/2 device-to-host frames and checks them, then buffers scancodes in a small FIFO. It drives a level interrupt into the IRQ controller's `intr_in` vector.

## Interface
- `clk_freq`, default 50000000: system clock frequency in Hz.
- `fifo_depth`, default 8: scancode FIFO entries; must be a power of two, ≥2.
- `timeout_cycles`, default 50000: maximum number of `clk` cycles between PS/2 falling edges within one frame before the frame is aborted (1 ms at 50 MHz).

Ports:
- `clk` in 1: system clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cs` in 1: port selected by the I/O decoder.
- `data_m_access` in 1: bus access strobe.
- `data_m_wr_en` in 1: 1 = write, 0 = read.
- `data_m_bytesel` in 2: byte lane enables; [0] = bits 7:0, [1] = bits 15:8.
- `data_m_data_in` in 16: write data.
- `data_m_data_out` out 16: read data; all-zero whenever `data_m_ack` is low, so the bus can be OR-combined.
- `data_m_ack` out 1: single-cycle completion.
- `ps2_clk` in 1: asynchronous PS/2 clock line, already tri-state-resolved.
- `ps2_dat` in 1: asynchronous PS/2 data line.
- `intr` out 1: level interrupt request.

## Operation
- **Input sync:** `ps2_clk` and `ps2_dat` each pass through a 2-flop synchroniser. A falling edge is detected when the synced clock's previous value is 1 and its current value is 0. Data is sampled on the synced falling edge.
- **Receive FSM:**
  - IDLE: on a falling edge with data 0 (start bit), go to DATA with bit count = 0. A falling edge with data 1 is ignored.
  - DATA: shift data in LSB first; after the 8th bit go to PARITY.
  - PARITY: capture the parity bit; go to STOP.
  - STOP: on the falling edge, the frame is good if the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity).
    - Good frame: push the byte to the FIFO and return to IDLE.
    - Bad frame: set `frame_err` and return to IDLE.
  - Timeout: in any state other than IDLE, a counter reloads on every falling edge. Reaching `timeout_cycles` returns the FSM to IDLE, discards the partial byte and sets no flag.
- **FIFO:** circular buffer with read and write pointers of width log2(`fifo_depth`) that wrap at the depth, plus a count of width log2(`fifo_depth`)+1.
  - Push when full: the byte is dropped and `overflow` is set.
  - Pop and push in the same cycle: the pop is applied first, so a push to a full FIFO that is popped in that cycle succeeds, with no overflow. The count is unchanged.
  - Pop when empty: ignored.
- **Read word:**
  - [7:0] head byte (0 when empty)
  - [8] valid (FIFO not empty)
  - [9] `overflow`
  - [10] `frame_err`
  - [11] `irq_en`
  - [15:12] 0
  - Reads have no side effects.
- **Write:** applies only when `data_m_bytesel[1]` is 1; writes with `bytesel` = 2'b01 are acked but have no effect. Each bit below acts only when written as 1, except `irq_en`, which takes the written value:
  - bit 15 = 1 pops the head.
  - bit 14 = 1 clears `overflow` and `frame_err`.
  - bit 11 loads `irq_en`.
- **Interrupt:** `intr` = `irq_en` & FIFO not empty, registered.
- **Reset values:**
  - `data_m_ack` = 0, `data_m_data_out` = 0, `intr` = 0.
  - FIFO empty, pointers = 0.
  - `overflow` = 0, `frame_err` = 0, `irq_en` = 0.
  - FSM in IDLE, synchronisers = 1.
- Reset asserted mid-frame or mid-access aborts everything to the reset values. The first frame after release must begin with a fresh start bit.

## Timing
- Access: `data_m_ack` is 1 in the cycle after `cs` & `data_m_access`, for exactly one cycle. `data_m_ack` is registered as `cs & data_m_access & ~data_m_ack`.
- `data_m_data_out` is valid in the ack cycle and reflects state as of the access cycle.
- Write effects are sampled in the access cycle and are visible from the ack cycle onwards.
- Edge-to-push latency:
  - 2 synchroniser cycles + 1 edge-detect cycle.
  - The byte is in the FIFO (valid = 1) 4 `clk` cycles after the raw stop-bit falling edge.
  - `intr` rises 1 cycle later.
- After a pop write, `intr` falls in the cycle after the ack if the FIFO becomes empty.
- Supported `ps2_clk` rates are 10–16.7 kHz; no glitch filter beyond synchronisation.

## Test plan
- **Good frame:**
  - Stimulus: reset, write 0x0800 (`irq_en` = 1), then send a frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1).
  - Response: a read returns 0x091C; `intr` = 1.
  - Then write 0x8000: `intr` = 0, and a read returns 0x0800.
- **Parity error:**
  - Stimulus: send 0x1C with parity 1.
  - Response: a read returns 0x0400; FIFO empty; `intr` = 0.
  - Then write 0x4000: a read returns 0x0000.
- **Overflow:**
  - Stimulus: send 9 frames 0x01..0x09 with depth 8.
  - Response: a read returns 0x0301; 8 pops yield 0x01..0x08.
  - Next read returns 0x0200 (empty, `overflow` still set).
- **Timeout:**
  - Stimulus: send a start bit plus 3 data bits, stall for 60000 cycles, then send a full frame 0x5A.
  - Response: a read returns 0x015A; no error bits set.
- **Simultaneous push/pop at full:**
  - Stimulus: fill with 8 bytes, then issue a pop write in the same cycle as the 9th byte's push.
  - Response: `overflow` = 0; the next 8 pops return bytes 2..9 in order.
- **Async reset mid-frame:**
  - Stimulus: assert `reset_n` = 0 after the 5th bit, release, then send 0x33.
  - Response: a read returns 0x0133.
  - Also check that all outputs are 0 during reset.
